// File: rtl/map_engine_pkg.sv
// rtl/map_engine_pkg.sv - shared types and helpers for the EV map engine (MAP_SAT_EN enables ADDS)
package map_engine_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_AND  = 3'd3,
        OP_OR   = 3'd4,
        OP_MINU = 3'd5,
        OP_MAXU = 3'd6,
        OP_ADDS = 3'd7
    } map_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } map_state_e;

    // Argument fields are sized for the largest EV the engine is expected to see.
    localparam int ARG_W = 16;

    typedef struct packed {
        logic [ARG_W-1:0] dst;
        logic [ARG_W-1:0] src;
        logic [ARG_W:0]   len;
        map_op_e          op;
    } map_args_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic logic range_ok(input int unsigned start, input int unsigned len,
                                      input int unsigned words);
        return (start + len) <= words;
    endfunction

    function automatic logic op_supported(input map_op_e op);
`ifdef MAP_SAT_EN
        return 1'b1;
`else
        return op != OP_ADDS;
`endif
    endfunction

endpackage

// File: rtl/map_engine_lane.sv
// rtl/map_engine_lane.sv - combinational single-word map ALU (MAP_SAT_EN adds signed saturating add)
module map_lane
    import map_engine_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    logic [31:0] sum;

    always_comb begin
        sum = a + b;
        y   = a;
        case (map_op_e'(op))
            OP_ADD:  y = sum;
            OP_SUB:  y = a - b;
            OP_XOR:  y = a ^ b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_MINU: y = (a < b) ? a : b;
            OP_MAXU: y = (a > b) ? a : b;
`ifdef MAP_SAT_EN
            // Signed overflow only when both operands share a sign the sum lost.
            OP_ADDS: y = ((a[31] == b[31]) && (sum[31] != a[31]))
                         ? (a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum;
`endif
            default: y = a;
        endcase
    end

endmodule

// File: rtl/map_engine.sv
// rtl/map_engine.sv - multi-cycle LANES-wide element-wise map over the EV (MAP_SAT_EN enables ADDS)
module map_engine
    import map_engine_pkg::*;
#(
    parameter int EV_WORDS = 64,
    parameter int LANES    = 4,
    parameter int ADDR_W   = $clog2(EV_WORDS),
    parameter int LEN_W    = $clog2(EV_WORDS) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EV_WORDS*32-1:0] in_ev,
    input  logic [ADDR_W-1:0]      in_dst,
    input  logic [ADDR_W-1:0]      in_src,
    input  logic [LEN_W-1:0]       in_len,
    input  logic [2:0]             in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EV_WORDS*32-1:0] out_ev,
    output logic                   out_err,
    output logic                   busy
);

    map_state_e       state_q, state_d;
    logic [31:0]      w_q [EV_WORDS];
    logic [31:0]      w_d [EV_WORDS];
    logic [31:0]      s_q [EV_WORDS];
    logic [31:0]      s_d [EV_WORDS];
    map_args_t        args_q, args_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;

    logic             accept;
    logic             req_err;
    logic             run_last;

    logic [31:0]      lane_pos [LANES];
    logic             lane_en  [LANES];
    logic [ADDR_W-1:0] lane_dst [LANES];
    logic [ADDR_W-1:0] lane_src [LANES];
    logic [31:0]      lane_a   [LANES];
    logic [31:0]      lane_b   [LANES];
    logic [31:0]      lane_y   [LANES];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            w_q     <= '{default: '0};
            s_q     <= '{default: '0};
            args_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            s_q     <= s_d;
            args_q  <= args_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        accept   = in_valid && (state_q == ST_IDLE);
        req_err  = !range_ok(32'(in_dst), 32'(in_len), EV_WORDS)
                || !range_ok(32'(in_src), 32'(in_len), EV_WORDS)
                || !op_supported(map_op_e'(in_op));
        run_last = (32'(idx_q) + 32'(LANES)) >= 32'(args_q.len);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (req_err || (in_len == '0)) ? ST_DONE : ST_RUN;
            ST_RUN:  if (run_last) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
        out_valid = (state_q == ST_DONE);
        out_err   = (state_q == ST_DONE) && err_q;
        out_ev    = '0;
        for (int k = 0; k < EV_WORDS; k++) begin
            out_ev[32*k +: 32] = w_q[k];
        end
    end

    // Lane addressing: destination operand from W, source operand always from the snapshot.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_pos[j] = 32'(idx_q) + 32'(j);
            lane_en[j]  = (state_q == ST_RUN) && (lane_pos[j] < 32'(args_q.len));
            lane_dst[j] = ADDR_W'(32'(args_q.dst) + lane_pos[j]);
            lane_src[j] = ADDR_W'(32'(args_q.src) + lane_pos[j]);
            lane_a[j]   = w_q[lane_dst[j]];
            lane_b[j]   = s_q[lane_src[j]];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        map_lane u_lane (
            .op (args_q.op),
            .a  (lane_a[g]),
            .b  (lane_b[g]),
            .y  (lane_y[g])
        );
    end

    always_comb begin
        w_d    = w_q;
        s_d    = s_q;
        args_d = args_q;
        idx_d  = idx_q;
        err_d  = err_q;
        if (accept) begin
            for (int k = 0; k < EV_WORDS; k++) begin
                w_d[k] = in_ev[32*k +: 32];
                s_d[k] = in_ev[32*k +: 32];
            end
            args_d.dst = ARG_W'(in_dst);
            args_d.src = ARG_W'(in_src);
            args_d.len = (ARG_W+1)'(in_len);
            args_d.op  = map_op_e'(in_op);
            idx_d      = '0;
            err_d      = req_err;
        end else if (state_q == ST_RUN) begin
            for (int j = 0; j < LANES; j++) begin
                if (lane_en[j]) w_d[lane_dst[j]] = lane_y[j];
            end
            idx_d = idx_q + LEN_W'(LANES);
        end
    end

endmodule

// File: tb/tb_map_engine.sv
// tb/tb_map_engine.sv - directed self-checking bench for map_engine
module tb_map_engine;

    localparam int EVW   = 64;
    localparam int LN    = 4;
    localparam int AW    = 6;
    localparam int LW    = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [EVW*32-1:0] in_ev;
    logic [AW-1:0]     in_dst;
    logic [AW-1:0]     in_src;
    logic [LW-1:0]     in_len;
    logic [2:0]        in_op;
    logic              out_valid;
    logic              out_ready;
    logic [EVW*32-1:0] out_ev;
    logic              out_err;
    logic              busy;

    logic [EVW*32-1:0] ev_in;
    logic [EVW*32-1:0] ev_exp;
    logic [EVW*32-1:0] held;
    int                n_pass = 0;
    int                n_total = 0;
    int                lat;

    map_engine #(.EV_WORDS(EVW), .LANES(LN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ev     (in_ev),
        .in_dst    (in_dst),
        .in_src    (in_src),
        .in_len    (in_len),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ev    (out_ev),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic chk_ev(input string tag, input logic [EVW*32-1:0] obs, input logic [EVW*32-1:0] exp);
        int bad;
        bad = 0;
        for (int k = EVW - 1; k >= 0; k--) begin
            if (obs[32*k +: 32] !== exp[32*k +: 32]) bad = k;
        end
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: word %0d observed=%08h expected=%08h",
                    tag, bad, obs[32*bad +: 32], exp[32*bad +: 32]);
    endtask

    task automatic setw(input int k, input logic [31:0] v);
        ev_in[32*k +: 32] = v;
    endtask

    task automatic setx(input int k, input logic [31:0] v);
        ev_exp[32*k +: 32] = v;
    endtask

    task automatic do_req(input int dst, input int src, input int len, input int op, output int l);
        @(negedge clk);
        in_dst   = AW'(dst);
        in_src   = AW'(src);
        in_len   = LW'(len);
        in_op    = 3'(op);
        in_ev    = ev_in;
        in_valid = 1'b1;
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 64) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);
    endtask

    logic [31:0] op_a   [6] = '{32'd5, 32'd1, 32'd1, 32'h0000F0F0, 32'h0000F0F0, 32'h0000F0F0};
    logic [31:0] op_b   [6] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000FF0, 32'h00000FF0, 32'h00000FF0};
    int          op_c   [6] = '{1, 5, 6, 2, 3, 4};
    logic [31:0] op_y   [6] = '{32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF, 32'h0000FF00, 32'h000000F0, 32'h0000FFF0};

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_ev = '0; in_dst = '0; in_src = '0; in_len = '0; in_op = '0;
        ev_in = '0; ev_exp = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk_ev("rst_out_ev", out_ev, '0);

        // Basic add, len 2
        ev_in = '0;
        setw(0, 10); setw(1, 11); setw(2, 12); setw(3, 13);
        ev_exp = ev_in;
        setx(0, 20); setx(1, 22);
        do_req(0, 0, 2, 0, lat);
        chk("t1_lat", 32'(lat), 32'd2);
        chk("t1_err", 32'(out_err), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        chk_ev("t1_ev", out_ev, ev_exp);
        release_out();

        // Signed data, len 8, separate source range
        ev_in = '0;
        setw(0, -67); setw(1, -15); setw(2, -24); setw(3, 47);
        setw(4, 26);  setw(5, 186); setw(6, -255); setw(7, 34567);
        setw(8, 32'hDEADBEEF);
        setw(16, -10); setw(17, -35); setw(18, 24); setw(19, -47);
        setw(20, 70);  setw(21, 57);  setw(22, -375); setw(23, 357);
        ev_exp = ev_in;
        setx(0, -77); setx(1, -50); setx(2, 0); setx(3, 0);
        setx(4, 96);  setx(5, 243); setx(6, -630); setx(7, 34924);
        do_req(0, 16, 8, 0, lat);
        chk("t2_lat", 32'(lat), 32'd3);
        chk("t2_w8", out_ev[32*8 +: 32], 32'hDEADBEEF);
        chk_ev("t2_ev", out_ev, ev_exp);
        release_out();

        // Overlapping ranges read sources from the snapshot
        ev_in = '0;
        for (int k = 0; k < 6; k++) setw(k, 32'(k + 1));
        ev_exp = ev_in;
        setx(0, 4); setx(1, 6); setx(2, 8); setx(3, 10);
        do_req(0, 2, 4, 0, lat);
        chk("t3_lat", 32'(lat), 32'd2);
        chk_ev("t3_ev", out_ev, ev_exp);
        release_out();

        // Range error at the top of the EV
        ev_in = '0;
        for (int k = 0; k < EVW; k++) setw(k, 32'h01010101 * 32'(k));
        do_req(EVW - 2, 0, 3, 0, lat);
        chk("t4_lat", 32'(lat), 32'd1);
        chk("t4_err", 32'(out_err), 32'd1);
        chk_ev("t4_ev", out_ev, ev_in);
        release_out();

        // Zero-length request
        do_req(5, 9, 0, 0, lat);
        chk("t5_lat", 32'(lat), 32'd1);
        chk("t5_err", 32'(out_err), 32'd0);
        chk_ev("t5_ev", out_ev, ev_in);
        release_out();

`ifdef MAP_SAT_EN
        ev_in = '0;
        setw(0, 32'h7FFFFFF0); setw(1, 32'h80000001);
        setw(8, 32'h00000020); setw(9, 32'hFFFFFFF0);
        do_req(0, 8, 2, 7, lat);
        chk("sat_err", 32'(out_err), 32'd0);
        chk("sat_pos", out_ev[31:0], 32'h7FFFFFFF);
        chk("sat_neg", out_ev[63:32], 32'h80000000);
        release_out();
`else
        ev_in = '0;
        setw(0, 32'h7FFFFFF0); setw(1, 32'h20);
        do_req(0, 1, 1, 7, lat);
        chk("op7_lat", 32'(lat), 32'd1);
        chk("op7_err", 32'(out_err), 32'd1);
        chk_ev("op7_ev", out_ev, ev_in);
        release_out();
`endif

        // Remaining ops, one word each
        for (int t = 0; t < 6; t++) begin
            ev_in = '0;
            setw(0, op_a[t]); setw(1, op_b[t]);
            do_req(0, 1, 1, op_c[t], lat);
            chk($sformatf("op%0d_y", op_c[t]), out_ev[31:0], op_y[t]);
            chk($sformatf("op%0d_src", op_c[t]), out_ev[63:32], op_b[t]);
            release_out();
        end

        // Backpressure: result holds while a new request is offered and ignored
        ev_in = '0;
        for (int k = 0; k < 4; k++) setw(k, 32'(100 + k));
        for (int k = 4; k < 8; k++) setw(k, 32'(k));
        ev_exp = ev_in;
        for (int k = 0; k < 4; k++) setx(k, 32'(100 + 2 * k + 4));
        do_req(0, 4, 4, 0, lat);
        chk("bp_lat", 32'(lat), 32'd2);
        held = out_ev;
        @(negedge clk);
        in_ev = '1; in_len = LW'(1); in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk_ev($sformatf("bp_hold%0d", c), out_ev, held);
            chk($sformatf("bp_ready%0d", c), 32'(in_ready), 32'd0);
            chk($sformatf("bp_valid%0d", c), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        chk_ev("bp_ev", out_ev, ev_exp);
        release_out();

        // Reset in the second RUN cycle of a 4-cycle run
        ev_in = '0;
        for (int k = 0; k < 32; k++) setw(k, 32'(k + 7));
        @(negedge clk);
        in_dst = '0; in_src = AW'(16); in_len = LW'(16); in_op = 3'd0;
        in_ev = ev_in; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mr_busy_run", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("mr_no_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk_ev("mr_out_ev", out_ev, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
